// File: rtl/gate_bist.sv
// Exhaustive two-input gate BIST: walks every operand pair, compares the gate result
// against OP and reports a mismatch count. Optional first-fail capture: GATE_BIST_FAIL_CAPTURE_EN.
module gate_bist #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned OP     = 0,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 START,
  input  logic                 ABORT,
  output logic [WIDTH-1:0]     DUT_IN0,
  output logic [WIDTH-1:0]     DUT_IN1,
  input  logic [WIDTH-1:0]     DUT_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [15:0]          ERR_CNT,
  output logic [2*WIDTH-1:0]   FAIL_IDX,
  output logic [WIDTH-1:0]     FAIL_OBS
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, CMPL} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [WIDTH-1:0]   in0_q, in0_d;
  logic [WIDTH-1:0]   in1_q, in1_d;
  logic [WIDTH-1:0]   exp_c;
  logic               mismatch_c;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
  logic               first_q, first_d;
  logic [IW-1:0]      fail_idx_q, fail_idx_d;
  logic [WIDTH-1:0]   fail_obs_q, fail_obs_d;
`endif

  // Reference gate evaluated on the operands currently driven out
  always_comb begin
    exp_c = '0;
    case (OP)
      0:       exp_c = in0_q & in1_q;
      1:       exp_c = in0_q | in1_q;
      2:       exp_c = in0_q ^ in1_q;
      3:       exp_c = ~(in0_q & in1_q);
      4:       exp_c = ~(in0_q | in1_q);
      5:       exp_c = ~(in0_q ^ in1_q);
      default: exp_c = '0;
    endcase
  end

  assign mismatch_c = (state_q == SAMPLE) && (DUT_OUT != exp_c);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    first_d    = first_q;
    fail_idx_d = fail_idx_q;
    fail_obs_d = fail_obs_q;
`endif
    case (state_q)
      IDLE, CMPL: begin
        if (START) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
          first_d = 1'b0;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(SETTLE - 1)) state_d = SAMPLE;
        else                          cnt_d   = cnt_q + CW'(1);
      end
      SAMPLE: begin
        if (mismatch_c) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
          if (!first_q) begin
            first_d    = 1'b1;
            fail_idx_d = idx_q;
            fail_obs_d = DUT_OUT;
          end
`endif
        end
        if (idx_q == {IW{1'b1}}) begin
          state_d = CMPL;
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + IW'(1);
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a start or a sample in the same cycle
    if (ABORT) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      err_d   = err_q;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
      first_d    = first_q;
      fail_idx_d = fail_idx_q;
      fail_obs_d = fail_obs_q;
`endif
    end

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == CMPL);
    pass_d = (state_d == CMPL) && (err_d == 16'd0);
    in0_d  = busy_d ? idx_d[WIDTH-1:0]  : '0;
    in1_d  = busy_d ? idx_d[IW-1:WIDTH] : '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      in0_q   <= '0;
      in1_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
    end
  end

`ifdef GATE_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      first_q    <= 1'b0;
      fail_idx_q <= '0;
      fail_obs_q <= '0;
    end else begin
      first_q    <= first_d;
      fail_idx_q <= fail_idx_d;
      fail_obs_q <= fail_obs_d;
    end
  end

  assign FAIL_IDX = fail_idx_q;
  assign FAIL_OBS = fail_obs_q;
`else
  assign FAIL_IDX = '0;
  assign FAIL_OBS = '0;
`endif

  assign DUT_IN0 = in0_q;
  assign DUT_IN1 = in1_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: two instances (1-bit AND, 2-bit XOR) driven by behavioural gates
// with selectable faults; run expectations are queued at START and checked at completion.
module tb_gate_bist;

`ifdef GATE_BIST_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic       CLK;
  logic       RSTn;
  logic       start_a, abort_a, start_b, abort_b;
  logic [0:0] in0_a, in1_a, out_a, obs_a;
  logic [1:0] fidx_a;
  logic [1:0] in0_b, in1_b, out_b, obs_b;
  logic [3:0] fidx_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, err_b;
  logic [2:0] fault_a;
  logic       fault_b;
  logic       sel;

  logic        busy_m, done_m, pass_m;
  logic [15:0] err_m;
  logic [1:0]  in0_m, in1_m, obs_m;
  logic [3:0]  fidx_m;

  int checks = 0;
  int errors = 0;

  gate_bist #(.WIDTH(1), .OP(0), .SETTLE(1)) u_a (
    .CLK(CLK), .RSTn(RSTn), .START(start_a), .ABORT(abort_a),
    .DUT_IN0(in0_a), .DUT_IN1(in1_a), .DUT_OUT(out_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a),
    .FAIL_IDX(fidx_a), .FAIL_OBS(obs_a));

  gate_bist #(.WIDTH(2), .OP(2), .SETTLE(3)) u_b (
    .CLK(CLK), .RSTn(RSTn), .START(start_b), .ABORT(abort_b),
    .DUT_IN0(in0_b), .DUT_IN1(in1_b), .DUT_OUT(out_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b),
    .FAIL_IDX(fidx_b), .FAIL_OBS(obs_b));

  // Gates under test: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 stuck-0, 5 stuck-1
  always_comb begin
    case (fault_a)
      3'd0:    out_a = in0_a & in1_a;
      3'd1:    out_a = in0_a | in1_a;
      3'd2:    out_a = in0_a ^ in1_a;
      3'd3:    out_a = ~(in0_a & in1_a);
      3'd4:    out_a = 1'b0;
      default: out_a = 1'b1;
    endcase
  end
  assign out_b = fault_b ? (in0_b & in1_b) : (in0_b ^ in1_b);

  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign pass_m = sel ? pass_b : pass_a;
  assign err_m  = sel ? err_b  : err_a;
  assign in0_m  = sel ? in0_b  : {1'b0, in0_a};
  assign in1_m  = sel ? in1_b  : {1'b0, in1_a};
  assign fidx_m = sel ? fidx_b : {2'b00, fidx_a};
  assign obs_m  = sel ? obs_b  : {1'b0, obs_a};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        s;
    logic [2:0]  flt;
    logic [15:0] err;
    logic [3:0]  fidx;
    logic [1:0]  fobs;
    string       nm;
  } vec_t;

  typedef struct {
    int          cycles;
    logic [15:0] err;
    logic        pass;
    logic [3:0]  fidx;
    logic [1:0]  fobs;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] last_fidx[2];
  logic [1:0] last_fobs[2];
  vec_t       tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_capture();
    for (int i = 0; i < 2; i++) begin
      last_fidx[i] = '0;
      last_fobs[i] = '0;
    end
  endtask

  task automatic run(input logic s, input logic [2:0] flt, input logic [15:0] e_err,
                     input logic [3:0] e_fidx, input logic [1:0] e_fobs, input string nm);
    exp_t e;
    int k, per, w, idx;
    sel = s;
    if (s) fault_b = flt[0];
    else   fault_a = flt;
    per = s ? 4 : 2;
    w   = s ? 2 : 1;
    if (e_err != 0) begin
      last_fidx[s] = e_fidx;
      last_fobs[s] = e_fobs;
    end
    e.cycles = s ? 64 : 8;
    e.err    = e_err;
    e.pass   = (e_err == 16'd0);
    e.fidx   = CAP ? last_fidx[s] : 4'd0;
    e.fobs   = CAP ? last_fobs[s] : 2'd0;
    sb.push_back(e);

    @(negedge CLK);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    start_b = 1'b0;
    k = 0;
    while (busy_m && k < 200) begin
      idx = k / per;
      chk({nm, "_in0"}, 32'(in0_m), 32'(idx & ((1 << w) - 1)));
      chk({nm, "_in1"}, 32'(in1_m), 32'(idx >> w));
      chk({nm, "_done_low"}, 32'(done_m), 32'd0);
      if (k == 0) chk({nm, "_err_clr"}, 32'(err_m), 32'd0);
      k++;
      @(negedge CLK);
    end
    e = sb.pop_front();
    chk({nm, "_busy_cycles"}, 32'(k), 32'(e.cycles));
    chk({nm, "_done"}, 32'(done_m), 32'd1);
    chk({nm, "_pass"}, 32'(pass_m), 32'(e.pass));
    chk({nm, "_err"}, 32'(err_m), 32'(e.err));
    chk({nm, "_fidx"}, 32'(fidx_m), 32'(e.fidx));
    chk({nm, "_fobs"}, 32'(obs_m), 32'(e.fobs));
    chk({nm, "_idle_in"}, 32'({in0_m, in1_m}), 32'd0);
    repeat (2) @(negedge CLK);
    chk({nm, "_done_hold"}, 32'(done_m), 32'd1);
  endtask

  task automatic check_zero_a(input string nm);
    chk({nm, "_busy"}, 32'(busy_a), 32'd0);
    chk({nm, "_done"}, 32'(done_a), 32'd0);
    chk({nm, "_pass"}, 32'(pass_a), 32'd0);
    chk({nm, "_err"},  32'(err_a),  32'd0);
    chk({nm, "_in"},   32'({in0_a, in1_a}), 32'd0);
    chk({nm, "_fidx"}, 32'(fidx_a), 32'd0);
    chk({nm, "_fobs"}, 32'(obs_a),  32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 3'd0, 16'd0, 4'd0, 2'd0, "and_ok"};
    tbl[1] = '{1'b0, 3'd1, 16'd2, 4'd1, 2'd1, "or_dut"};
    tbl[2] = '{1'b0, 3'd0, 16'd0, 4'd0, 2'd0, "rerun_ok"};
    tbl[3] = '{1'b0, 3'd2, 16'd3, 4'd1, 2'd1, "xor_dut"};
    tbl[4] = '{1'b0, 3'd4, 16'd1, 4'd3, 2'd0, "stuck0"};
    tbl[5] = '{1'b0, 3'd3, 16'd4, 4'd0, 2'd1, "nand_dut"};
    tbl[6] = '{1'b0, 3'd5, 16'd3, 4'd0, 2'd1, "stuck1"};
    tbl[7] = '{1'b1, 3'd0, 16'd0, 4'd0, 2'd0, "w2_xor_ok"};
    tbl[8] = '{1'b1, 3'd1, 16'd15, 4'd1, 2'd0, "w2_and_dut"};

    RSTn = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    fault_a = 3'd0; fault_b = 1'b0; sel = 1'b0;
    clear_capture();
    #1;
    check_zero_a("reset");
    chk("reset_busy_b", 32'(busy_b), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_wait", 32'(busy_a), 32'd0);

    for (int i = 0; i < 9; i++)
      run(tbl[i].s, tbl[i].flt, tbl[i].err, tbl[i].fidx, tbl[i].fobs, tbl[i].nm);

    // Abort together with start while pattern 2 is being driven
    sel = 1'b0;
    fault_a = 3'd1;
    @(negedge CLK);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_at_idx2", 32'({in1_a, in0_a}), 32'd2);
    abort_a = 1'b1;
    start_a = 1'b1;
    @(negedge CLK);
    abort_a = 1'b0;
    start_a = 1'b0;
    last_fidx[0] = 4'd1;
    last_fobs[0] = 2'd1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_pass", 32'(pass_a), 32'd0);
    chk("abort_in", 32'({in0_a, in1_a}), 32'd0);
    chk("abort_err_kept", 32'(err_a), 32'd1);
    chk("abort_fidx_kept", 32'(fidx_a), CAP ? 32'd1 : 32'd0);
    chk("abort_fobs_kept", 32'(obs_a), CAP ? 32'd1 : 32'd0);
    repeat (2) @(negedge CLK);
    chk("abort_stays_idle", 32'(busy_a), 32'd0);

    // Asynchronous reset between clock edges in the middle of a run
    fault_a = 3'd0;
    @(negedge CLK);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_reset_busy", 32'(busy_a), 32'd1);
    #2 RSTn = 1'b0;
    #1;
    check_zero_a("async_rst");
    @(negedge CLK);
    RSTn = 1'b1;
    clear_capture();
    repeat (3) @(negedge CLK);
    chk("post_rst_idle", 32'(busy_a), 32'd0);
    run(1'b0, 3'd0, 16'd0, 4'd0, 2'd0, "post_rst_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
